// File: rtl/cci_mpf_shim_rd_tag_sched.sv
// Read-request tag scheduler: hands out unique low-Mdata tags from a free list and restores the AFU Mdata on responses.
// Optional checker enabled by defining CCI_MPF_RD_TAG_SCHED_CHECK_EN (allocated bitmap + sticky err).
module cci_mpf_shim_rd_tag_sched #(
    parameter int MAX_ACTIVE_REQS = 128,
    parameter int N_MDATA_BITS    = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    input  logic [N_MDATA_BITS-1:0]            req_mdata,
    input  logic [1:0]                         req_len,
    output logic                               req_rdy,
    input  logic                               fiu_almfull,
    output logic                               tx_valid,
    output logic [N_MDATA_BITS-1:0]            tx_mdata,
    output logic [1:0]                         tx_len,
    input  logic                               rsp_valid,
    input  logic [N_MDATA_BITS-1:0]            rsp_mdata,
    input  logic                               rsp_eop,
    output logic                               afu_rsp_valid,
    output logic [N_MDATA_BITS-1:0]            afu_rsp_mdata,
    output logic                               afu_rsp_eop,
    output logic [$clog2(MAX_ACTIVE_REQS):0]   active_cnt,
    output logic                               err
);

    localparam int TW = $clog2(MAX_ACTIVE_REQS);
    localparam logic [TW:0]   MAX_CNT  = (TW+1)'(MAX_ACTIVE_REQS);
    localparam logic [TW-1:0] LAST_IDX = TW'(MAX_ACTIVE_REQS - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              r_state;
    logic [TW-1:0]           r_initIdx;
    logic [TW-1:0]           r_freeList [MAX_ACTIVE_REQS];
    logic [N_MDATA_BITS-1:0] r_save [MAX_ACTIVE_REQS];
    logic [TW:0]             r_head;
    logic [TW:0]             r_tail;
    logic                    r_pushValid;
    logic [TW-1:0]           r_pushTag;
    logic                    r_txValid;
    logic [N_MDATA_BITS-1:0] r_txMdata;
    logic [1:0]              r_txLen;
    logic                    r_afuRspValid;
    logic [N_MDATA_BITS-1:0] r_afuRspMdata;
    logic                    r_afuRspEop;

    logic [TW:0]             w_freeCnt;
    logic                    w_run;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_accept;
    logic [TW-1:0]           w_popTag;
    logic [TW-1:0]           w_rspTag;
    logic                    w_pushOk;
    logic                    w_unusedRspBits;

    assign w_freeCnt       = r_tail - r_head;
    assign w_run           = (r_state == ST_RUN);
    assign w_empty         = (w_freeCnt == '0);
    assign w_full          = (w_freeCnt == MAX_CNT);
    assign req_rdy         = w_run && !w_empty && !fiu_almfull;
    assign w_accept        = req_valid && req_rdy;
    assign w_popTag        = r_freeList[r_head[TW-1:0]];
    assign w_rspTag        = rsp_mdata[TW-1:0];
    assign w_pushOk        = r_pushValid && !w_full;
    assign w_unusedRspBits = ^rsp_mdata[N_MDATA_BITS-1:TW];

    // INIT walks every free-list entry once; the tail already points one full lap ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_initIdx <= '0;
        end else if (r_state == ST_INIT) begin
            r_initIdx <= r_initIdx + 1'b1;
            if (r_initIdx == LAST_IDX) r_state <= ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= MAX_CNT;
        end else begin
            if (w_accept) r_head <= r_head + 1'b1;
            if (w_pushOk) r_tail <= r_tail + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT)
            r_freeList[r_initIdx] <= r_initIdx;
        else if (w_pushOk)
            r_freeList[r_tail[TW-1:0]] <= r_pushTag;
        if (w_accept)
            r_save[w_popTag] <= req_mdata;
    end

    // Responses arriving in INIT are dropped so stale tags never re-enter the list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txValid     <= 1'b0;
            r_afuRspValid <= 1'b0;
            r_afuRspEop   <= 1'b0;
            r_pushValid   <= 1'b0;
        end else begin
            r_txValid     <= w_accept;
            r_afuRspValid <= rsp_valid && w_run;
            r_afuRspEop   <= rsp_valid && rsp_eop && w_run;
            r_pushValid   <= rsp_valid && rsp_eop && w_run;
        end
        if (w_accept) begin
            r_txMdata <= {req_mdata[N_MDATA_BITS-1:TW], w_popTag};
            r_txLen   <= req_len;
        end
        r_afuRspMdata <= r_save[w_rspTag];
        r_pushTag     <= w_rspTag;
    end

    assign tx_valid      = r_txValid;
    assign tx_mdata      = r_txMdata;
    assign tx_len        = r_txLen;
    assign afu_rsp_valid = r_afuRspValid;
    assign afu_rsp_mdata = r_afuRspMdata;
    assign afu_rsp_eop   = r_afuRspEop;
    assign active_cnt    = MAX_CNT - w_freeCnt;

`ifdef CCI_MPF_RD_TAG_SCHED_CHECK_EN
    logic [MAX_ACTIVE_REQS-1:0] r_alloc;
    logic                       r_err;
    logic                       w_errRsp;
    logic                       w_errPush;
    logic                       w_errPop;

    assign w_errRsp  = rsp_valid && w_run && !r_alloc[w_rspTag];
    assign w_errPush = r_pushValid && w_full;
    assign w_errPop  = w_accept && r_alloc[w_popTag];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pushOk) r_alloc[r_pushTag] <= 1'b0;
            if (w_accept) r_alloc[w_popTag] <= 1'b1;
            if (w_errRsp || w_errPush || w_errPop) r_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_errRsp)  $error("rd_tag_sched: response for unallocated tag %0d", w_rspTag);
            if (w_errPush) $error("rd_tag_sched: push of tag %0d into full free list", r_pushTag);
            if (w_errPop)  $error("rd_tag_sched: pop returned allocated tag %0d", w_popTag);
        end
    end
`endif

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_rd_tag_sched.sv
// Directed self-checking bench for cci_mpf_shim_rd_tag_sched (128 tags, 16-bit Mdata).
// Expected err follows CCI_MPF_RD_TAG_SCHED_CHECK_EN.
module tb_cci_mpf_shim_rd_tag_sched;

    localparam int MAX = 128;
    localparam int N   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_mdata = '0;
    logic [1:0]  req_len = '0;
    logic        req_rdy;
    logic        fiu_almfull = 1'b0;
    logic        tx_valid;
    logic [15:0] tx_mdata;
    logic [1:0]  tx_len;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_mdata = '0;
    logic        rsp_eop = 1'b0;
    logic        afu_rsp_valid;
    logic [15:0] afu_rsp_mdata;
    logic        afu_rsp_eop;
    logic [7:0]  active_cnt;
    logic        err;

    int nAsserts = 0;
    int nFails   = 0;
    int cyc;

`ifdef CCI_MPF_RD_TAG_SCHED_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    cci_mpf_shim_rd_tag_sched #(.MAX_ACTIVE_REQS(MAX), .N_MDATA_BITS(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_mdata(req_mdata), .req_len(req_len), .req_rdy(req_rdy),
        .fiu_almfull(fiu_almfull),
        .tx_valid(tx_valid), .tx_mdata(tx_mdata), .tx_len(tx_len),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_eop(rsp_eop),
        .afu_rsp_valid(afu_rsp_valid), .afu_rsp_mdata(afu_rsp_mdata), .afu_rsp_eop(afu_rsp_eop),
        .active_cnt(active_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request that must be accepted this cycle and show up on tx next cycle.
    task automatic applyStimulus(input logic [15:0] mdata, input logic [6:0] expTag);
        req_valid = 1'b1;
        req_mdata = mdata;
        req_len   = expTag[1:0];
        #1;
        checkOutput("req_rdy_issue", req_rdy, 1);
        tick();
        checkOutput("tx_valid_issue", tx_valid, 1);
        checkOutput("tx_mdata_issue", tx_mdata, {mdata[15:7], expTag});
        checkOutput("tx_len_issue", tx_len, expTag[1:0]);
    endtask

    task automatic sendRsp(input logic [15:0] mdata, input logic eop);
        rsp_valid = 1'b1;
        rsp_mdata = mdata;
        rsp_eop   = eop;
        tick();
        rsp_valid = 1'b0;
        rsp_eop   = 1'b0;
    endtask

    initial begin
        tick(); tick(); tick();
        checkOutput("rst_req_rdy", req_rdy, 0);
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_afu_rsp_valid", afu_rsp_valid, 0);
        checkOutput("rst_afu_rsp_eop", afu_rsp_eop, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_active_cnt", active_cnt, 0);

        // INIT length with a request held pending
        reset     = 1'b0;
        req_valid = 1'b1;
        req_mdata = 16'h1234;
        #1;
        cyc = 0;
        while (req_rdy !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        checkOutput("init_cycles", cyc, 128);
        checkOutput("init_tx_valid", tx_valid, 0);
        checkOutput("init_active_cnt", active_cnt, 0);

        for (int t = 0; t < 4; t++) applyStimulus(16'hC000 + 16'(t), 7'(t));
        applyStimulus(16'h1111, 7'd4);
        applyStimulus(16'hBEEF, 7'd5);
        req_valid = 1'b0;
        tick();
        checkOutput("idle_tx_valid", tx_valid, 0);
        checkOutput("active_after_6", active_cnt, 6);

        // Four-flit response for tag 5, EOP on the last flit only
        for (int f = 0; f < 4; f++) begin
            sendRsp(16'hBE85, f == 3);
            checkOutput("restore_valid", afu_rsp_valid, 1);
            checkOutput("restore_mdata", afu_rsp_mdata, 16'hBEEF);
            checkOutput("restore_eop", afu_rsp_eop, (f == 3) ? 1 : 0);
            checkOutput("restore_active", active_cnt, 6);
        end
        tick();
        checkOutput("restore_active_freed", active_cnt, 5);
        checkOutput("restore_valid_idle", afu_rsp_valid, 0);

        for (int t = 6; t <= 10; t++) applyStimulus(16'h2000 + 16'(t), 7'(t));
        req_valid = 1'b0;
        tick();
        checkOutput("active_10", active_cnt, 10);

        // EOP for tag 0; its push lands in the same cycle as the next pop
        sendRsp(16'h0000, 1'b1);
        checkOutput("sim_rsp_mdata", afu_rsp_mdata, 16'hC000);
        checkOutput("sim_active_pre", active_cnt, 10);
        applyStimulus(16'h3333, 7'd11);
        checkOutput("sim_active_post", active_cnt, 10);

        // Remaining free tags come out in FIFO order, freed tags last
        for (int t = 12; t < 128; t++) applyStimulus(16'h4000 + 16'(t), 7'(t));
        applyStimulus(16'h5555, 7'd5);
        applyStimulus(16'h6666, 7'd0);
        #1;
        checkOutput("full_req_rdy", req_rdy, 0);
        checkOutput("full_active", active_cnt, 128);
        tick();
        checkOutput("full_held_tx1", tx_valid, 0);
        tick();
        checkOutput("full_held_tx2", tx_valid, 0);
        checkOutput("full_active_hold", active_cnt, 128);
        req_valid = 1'b0;

        sendRsp(16'h0008, 1'b1);
        checkOutput("free8_mdata", afu_rsp_mdata, 16'h2008);
        sendRsp(16'h0007, 1'b1);
        checkOutput("free7_mdata", afu_rsp_mdata, 16'h2007);
        tick();
        checkOutput("active_126", active_cnt, 126);

        // Almost-full backpressure for three cycles
        fiu_almfull = 1'b1;
        req_valid   = 1'b1;
        req_mdata   = 16'h7777;
        for (int b = 0; b < 3; b++) begin
            #1;
            checkOutput("bp_req_rdy", req_rdy, 0);
            tick();
            checkOutput("bp_tx_valid", tx_valid, 0);
        end
        fiu_almfull = 1'b0;
        applyStimulus(16'h7777, 7'd8);
        req_valid = 1'b0;
        tick();
        checkOutput("active_127", active_cnt, 127);

        // EOP for tag 7, which is currently free
        sendRsp(16'h0007, 1'b1);
        checkOutput("chk_err_1", err, ERR_EXP);
        tick();
        checkOutput("chk_err_2", err, ERR_EXP);
        tick();
        checkOutput("chk_err_3", err, ERR_EXP);
        checkOutput("chk_active", active_cnt, 126);

        // Mid-operation reset with responses arriving during INIT
        reset = 1'b1;
        tick();
        checkOutput("rst2_err", err, 0);
        checkOutput("rst2_active", active_cnt, 0);
        checkOutput("rst2_req_rdy", req_rdy, 0);
        checkOutput("rst2_tx_valid", tx_valid, 0);
        reset     = 1'b0;
        rsp_valid = 1'b1;
        rsp_eop   = 1'b1;
        rsp_mdata = 16'h0003;
        req_valid = 1'b1;
        req_mdata = 16'h9999;
        #1;
        cyc = 0;
        while (req_rdy !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
            checkOutput("init2_afu_rsp_valid", afu_rsp_valid, 0);
        end
        rsp_valid = 1'b0;
        rsp_eop   = 1'b0;
        checkOutput("init2_cycles", cyc, 128);
        checkOutput("init2_active", active_cnt, 0);
        applyStimulus(16'h9999, 7'd0);
        req_valid = 1'b0;
        tick();
        checkOutput("post_rst_active", active_cnt, 1);
        checkOutput("post_rst_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
